// File: rtl/membus_pkg.sv
// Shared types for the register-bus arbiter: default widths, the owner tag
// used to route read data back, and the request record carried through the
// host pending buffer and the issue mux.
package membus_pkg;

  localparam int MEM_AW = 7;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_LOC  = 2'd2
  } owner_e;

  // Widths follow MEM_AW/MEM_DW; the arbiter parameters default to these.
  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/membus_if.sv
// Bundle of host, local-master and memory-side signals around the arbiter.
// slave = arbiter view, master = view of everything around it.
interface membus_if #(
  parameter int AW = 7,
  parameter int DW = 8
);

  logic          host_read_req_i;
  logic          host_write_req_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_data_i;
  logic [DW-1:0] host_data_o;
  logic          host_rvalid_o;

  logic          loc_req_i;
  logic          loc_we_i;
  logic [AW-1:0] loc_addr_i;
  logic [DW-1:0] loc_data_i;
  logic          loc_ack_o;
  logic [DW-1:0] loc_data_o;
  logic          loc_rvalid_o;

  logic          mem_read_req_o;
  logic          mem_write_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;

  logic          ovf_o;

  modport slave (
    input  host_read_req_i, host_write_req_i, host_addr_i, host_data_i,
    input  loc_req_i, loc_we_i, loc_addr_i, loc_data_i, mem_data_i,
    output host_data_o, host_rvalid_o, loc_ack_o, loc_data_o, loc_rvalid_o,
    output mem_read_req_o, mem_write_req_o, mem_addr_o, mem_data_o, ovf_o
  );

  modport master (
    output host_read_req_i, host_write_req_i, host_addr_i, host_data_i,
    output loc_req_i, loc_we_i, loc_addr_i, loc_data_i, mem_data_i,
    input  host_data_o, host_rvalid_o, loc_ack_o, loc_data_o, loc_rvalid_o,
    input  mem_read_req_o, mem_write_req_o, mem_addr_o, mem_data_o, ovf_o
  );

endinterface

// File: rtl/membus_req_buf.sv
// One-entry pending buffer for host strobes. A new strobe always loads;
// if the entry it replaces was not being issued that cycle, the old
// request is lost and the sticky ovf flag is raised.
module membus_req_buf
  import membus_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t din,
  output logic     valid,
  output mem_req_t dout,
  output logic     ovf
);

  // load on push, drain on pop, flag an overwrite of an unissued entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else if (push) begin
      dout  <= din;
      valid <= 1'b1;
      if (valid && !pop) ovf <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Two-master arbiter for the register memory bus. Host strobes are captured
// into a one-entry buffer and issued the next cycle with priority; the local
// req/ack master gets leftover slots, or is forced in after STARVE_MAX host
// issues while it waits. Read data is routed by a registered owner tag.
// Optional: define MEMBUS_ARB_STATS_EN for per-master issue counters.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  membus_if.slave     bus
`ifdef MEMBUS_ARB_STATS_EN
  ,
  output logic [15:0] host_cnt_o,
  output logic [15:0] loc_cnt_o
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  mem_req_t        host_in, pend, issue;
  logic            pend_vld, ovf;
  logic            force_loc, host_go, loc_go, issue_vld;
  logic [3:0]      starve_cnt;
  logic            loc_inflight;
  owner_e          owner;
  logic            rd_q;
  logic            host_rv, loc_rv;
  logic [DW-1:0]   host_data_q, loc_data_q;

  // both strobes in one cycle: the write is kept
  assign host_in = '{we:   bus.host_write_req_i,
                     addr: bus.host_addr_i,
                     data: bus.host_data_i};

  membus_req_buf u_req_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (bus.host_read_req_i | bus.host_write_req_i),
    .pop   (host_go),
    .din   (host_in),
    .valid (pend_vld),
    .dout  (pend),
    .ovf   (ovf)
  );

  // per-cycle arbitration and issue mux; nothing issues while in reset
  always_comb begin
    force_loc = bus.loc_req_i && (starve_cnt == STARVE_LIM);
    loc_go    = !rst_i && bus.loc_req_i &&
                (force_loc || (!pend_vld && !loc_inflight));
    host_go   = !rst_i && pend_vld && !force_loc;
    issue     = '0;
    issue_vld = 1'b0;
    if (host_go) begin
      issue     = pend;
      issue_vld = 1'b1;
    end else if (loc_go) begin
      issue     = '{we: bus.loc_we_i, addr: bus.loc_addr_i, data: bus.loc_data_i};
      issue_vld = 1'b1;
    end
  end

  assign bus.mem_write_req_o = issue_vld && issue.we;
  assign bus.mem_read_req_o  = issue_vld && !issue.we;
  assign bus.mem_addr_o      = issue.addr;
  assign bus.mem_data_o      = issue.we ? issue.data : '0;
  assign bus.loc_ack_o       = loc_go;
  assign bus.ovf_o           = ovf;

  // count host wins while local waits; any local issue or idle local resets it
  always_ff @(posedge clk_i) begin
    if (rst_i || loc_go || !bus.loc_req_i) starve_cnt <= '0;
    else if (host_go && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
  end

  // owner tag + read flag for next-cycle capture; in-flight guard for local
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner        <= OWN_NONE;
      rd_q         <= 1'b0;
      loc_inflight <= 1'b0;
    end else begin
      owner        <= host_go ? OWN_HOST : (loc_go ? OWN_LOC : OWN_NONE);
      rd_q         <= issue_vld && !issue.we;
      loc_inflight <= loc_go;
    end
  end

  // memory data is valid the cycle after the read strobe; a reset in that
  // cycle throws the read away
  assign host_rv = !rst_i && rd_q && (owner == OWN_HOST);
  assign loc_rv  = !rst_i && rd_q && (owner == OWN_LOC);

  // hold the last read value per master
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_data_q <= '0;
      loc_data_q  <= '0;
    end else begin
      if (host_rv) host_data_q <= bus.mem_data_i;
      if (loc_rv)  loc_data_q  <= bus.mem_data_i;
    end
  end

  assign bus.host_rvalid_o = host_rv;
  assign bus.loc_rvalid_o  = loc_rv;
  assign bus.host_data_o   = host_rv ? bus.mem_data_i : host_data_q;
  assign bus.loc_data_o    = loc_rv  ? bus.mem_data_i : loc_data_q;

`ifdef MEMBUS_ARB_STATS_EN
  // saturating issue counters per master
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_cnt_o <= '0;
      loc_cnt_o  <= '0;
    end else begin
      if (host_go && host_cnt_o != 16'hFFFF) host_cnt_o <= host_cnt_o + 16'd1;
      if (loc_go  && loc_cnt_o  != 16'hFFFF) loc_cnt_o  <= loc_cnt_o  + 16'd1;
    end
  end
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. The memory model
// answers a read of address A with A ^ 8'h2C one cycle after the strobe.
module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  membus_if #(.AW(7), .DW(8)) bus ();

`ifdef MEMBUS_ARB_STATS_EN
  logic [15:0] host_cnt, loc_cnt;
`endif

  membus_arbiter #(.AW(7), .DW(8), .STARVE_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef MEMBUS_ARB_STATS_EN
    ,
    .host_cnt_o (host_cnt),
    .loc_cnt_o  (loc_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_read_req_o) bus.mem_data_i <= {1'b0, bus.mem_addr_o} ^ 8'h2C;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.host_read_req_i  = 1'b0;
    bus.host_write_req_i = 1'b0;
    bus.host_addr_i      = '0;
    bus.host_data_i      = '0;
    bus.loc_req_i        = 1'b0;
    bus.loc_we_i         = 1'b0;
    bus.loc_addr_i       = '0;
    bus.loc_data_i       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    @(negedge clk);
    total++;
    if ({bus.mem_read_req_o, bus.mem_write_req_o, bus.loc_ack_o,
         bus.host_rvalid_o, bus.loc_rvalid_o, bus.ovf_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.mem_read_req_o,
               bus.mem_write_req_o, bus.loc_ack_o, bus.host_rvalid_o,
               bus.loc_rvalid_o, bus.ovf_o});
    end
    total++;
    if ({bus.mem_addr_o, bus.mem_data_o, bus.host_data_o, bus.loc_data_o} !== 31'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.mem_addr_o, bus.mem_data_o,
               bus.host_data_o, bus.loc_data_o});
    end
`ifdef MEMBUS_ARB_STATS_EN
    total++;
    if ({host_cnt, loc_cnt} !== 32'h0) begin
      bad++;
      $display("FAIL reset_stats: got %h want 0", {host_cnt, loc_cnt});
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_host_write();
    tick();
    bus.host_write_req_i = 1'b1; bus.host_addr_i = 7'h05; bus.host_data_i = 8'hA5;
    @(negedge clk);
    total++;
    if (bus.mem_write_req_o !== 1'b0) begin
      bad++; $display("FAIL wr_early: got %b want 0", bus.mem_write_req_o);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.mem_read_req_o, bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o} !==
        {1'b0, 1'b1, 7'h05, 8'hA5}) begin
      bad++; $display("FAIL wr_issue: got %b_%b_%h_%h want 0_1_05_a5", bus.mem_read_req_o,
                      bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o);
    end
    // read and write strobes together: write wins
    tick();
    bus.host_read_req_i = 1'b1; bus.host_write_req_i = 1'b1;
    bus.host_addr_i = 7'h06; bus.host_data_i = 8'h33;
    @(negedge clk);
    total++;
    if ({bus.mem_write_req_o, bus.host_rvalid_o, bus.loc_rvalid_o} !== 3'b000) begin
      bad++; $display("FAIL wr_no_rvalid: got %b want 000",
                      {bus.mem_write_req_o, bus.host_rvalid_o, bus.loc_rvalid_o});
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.mem_read_req_o, bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o} !==
        {1'b0, 1'b1, 7'h06, 8'h33}) begin
      bad++; $display("FAIL both_strobes: got %b_%b_%h_%h want 0_1_06_33", bus.mem_read_req_o,
                      bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.host_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL both_no_rvalid: got %b want 0", bus.host_rvalid_o);
    end
  endtask

  task automatic test_host_read();
    tick();
    bus.host_read_req_i = 1'b1; bus.host_addr_i = 7'h10;
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.mem_read_req_o, bus.mem_write_req_o, bus.mem_addr_o, bus.host_rvalid_o} !==
        {1'b1, 1'b0, 7'h10, 1'b0}) begin
      bad++; $display("FAIL rd_issue: got %b_%b_%h_%b want 1_0_10_0", bus.mem_read_req_o,
                      bus.mem_write_req_o, bus.mem_addr_o, bus.host_rvalid_o);
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.host_rvalid_o, bus.host_data_o, bus.loc_rvalid_o} !== {1'b1, 8'h3C, 1'b0}) begin
      bad++; $display("FAIL rd_data: got %b_%h_%b want 1_3c_0", bus.host_rvalid_o,
                      bus.host_data_o, bus.loc_rvalid_o);
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.host_rvalid_o, bus.host_data_o} !== {1'b0, 8'h3C}) begin
      bad++; $display("FAIL rd_hold: got %b_%h want 0_3c", bus.host_rvalid_o, bus.host_data_o);
    end
  endtask

  task automatic test_local_read();
    tick();
    bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b0; bus.loc_addr_i = 7'h20;
    @(negedge clk);
    total++;
    if ({bus.loc_ack_o, bus.mem_read_req_o, bus.mem_addr_o} !== {1'b1, 1'b1, 7'h20}) begin
      bad++; $display("FAIL loc_ack: got %b_%b_%h want 1_1_20", bus.loc_ack_o,
                      bus.mem_read_req_o, bus.mem_addr_o);
    end
    // request still held in the cycle after ack: no second ack
    tick();
    @(negedge clk);
    total++;
    if ({bus.loc_ack_o, bus.mem_read_req_o, bus.loc_rvalid_o, bus.loc_data_o} !==
        {1'b0, 1'b0, 1'b1, 8'h0C}) begin
      bad++; $display("FAIL loc_rdata: got %b_%b_%b_%h want 0_0_1_0c", bus.loc_ack_o,
                      bus.mem_read_req_o, bus.loc_rvalid_o, bus.loc_data_o);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.loc_ack_o, bus.loc_rvalid_o, bus.loc_data_o, bus.host_rvalid_o} !==
        {1'b0, 1'b0, 8'h0C, 1'b0}) begin
      bad++; $display("FAIL loc_after: got %b_%b_%h_%b want 0_0_0c_0", bus.loc_ack_o,
                      bus.loc_rvalid_o, bus.loc_data_o, bus.host_rvalid_o);
    end
  endtask

  task automatic test_host_loc_same();
    tick();
    bus.host_read_req_i = 1'b1; bus.host_addr_i = 7'h10;
    tick();
    bus.host_read_req_i = 1'b0;
    bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b1; bus.loc_addr_i = 7'h30; bus.loc_data_i = 8'h77;
    @(negedge clk);
    total++;
    if ({bus.mem_read_req_o, bus.mem_addr_o, bus.loc_ack_o} !== {1'b1, 7'h10, 1'b0}) begin
      bad++; $display("FAIL same_host_first: got %b_%h_%b want 1_10_0",
                      bus.mem_read_req_o, bus.mem_addr_o, bus.loc_ack_o);
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.loc_ack_o, bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o} !==
        {1'b1, 1'b1, 7'h30, 8'h77}) begin
      bad++; $display("FAIL same_loc_next: got %b_%b_%h_%h want 1_1_30_77", bus.loc_ack_o,
                      bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o);
    end
    total++;
    if ({bus.host_rvalid_o, bus.host_data_o} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL same_host_rdata: got %b_%h want 1_3c",
                      bus.host_rvalid_o, bus.host_data_o);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.loc_ack_o, bus.loc_rvalid_o, bus.mem_write_req_o} !== 3'b000) begin
      bad++; $display("FAIL same_after: got %b want 000",
                      {bus.loc_ack_o, bus.loc_rvalid_o, bus.mem_write_req_o});
    end
  endtask

  // host writes 0x40..0x45 in cycles 0..5, local read of 0x21 held in 1..5
  task automatic test_starve();
    logic [3:0] exp_ctl [8] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000,
                                4'b1000, 4'b0110, 4'b1001, 4'b0001};
    logic [6:0] exp_ad  [8] = '{7'h00, 7'h40, 7'h41, 7'h42,
                                7'h43, 7'h21, 7'h45, 7'h00};
    logic [7:0] exp_dt  [8] = '{8'h00, 8'h10, 8'h11, 8'h12,
                                8'h13, 8'h00, 8'h15, 8'h00};
    logic [3:0] got;
    for (int c = 0; c < 8; c++) begin
      tick();
      bus.host_write_req_i = (c <= 5);
      bus.host_addr_i      = 7'(7'h40 + c);
      bus.host_data_i      = 8'(8'h10 + c);
      bus.loc_req_i        = (c >= 1 && c <= 5);
      bus.loc_we_i         = 1'b0;
      bus.loc_addr_i       = 7'h21;
      @(negedge clk);
      got = {bus.mem_write_req_o, bus.mem_read_req_o, bus.loc_ack_o, bus.ovf_o};
      total++;
      if (got !== exp_ctl[c]) begin
        bad++; $display("FAIL starve_ctl c%0d: got %b want %b (wr rd ack ovf)",
                        c, got, exp_ctl[c]);
      end
      if (exp_ctl[c][3] || exp_ctl[c][2]) begin
        total++;
        if ({bus.mem_addr_o, bus.mem_data_o} !== {exp_ad[c], exp_dt[c]}) begin
          bad++; $display("FAIL starve_bus c%0d: got %h_%h want %h_%h", c,
                          bus.mem_addr_o, bus.mem_data_o, exp_ad[c], exp_dt[c]);
        end
      end
    end
    idle();
    tick();
    @(negedge clk);
    total++;
    if ({bus.loc_data_o, bus.ovf_o} !== {8'h0D, 1'b1}) begin
      bad++; $display("FAIL starve_locdata: got %h_%b want 0d_1", bus.loc_data_o, bus.ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.host_read_req_i = 1'b1; bus.host_addr_i = 7'h10;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (bus.mem_read_req_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_issue: got %b want 1", bus.mem_read_req_o);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.host_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_rvalid: got %b want 0", bus.host_rvalid_o);
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.host_rvalid_o, bus.host_data_o, bus.ovf_o, bus.loc_data_o,
         bus.mem_read_req_o, bus.mem_write_req_o} !== 20'h0) begin
      bad++; $display("FAIL rstmid_zero: got %b_%h_%b_%h_%b_%b want all 0", bus.host_rvalid_o,
                      bus.host_data_o, bus.ovf_o, bus.loc_data_o,
                      bus.mem_read_req_o, bus.mem_write_req_o);
    end
    tick();
    rst = 1'b0;
    tick();
    bus.host_write_req_i = 1'b1; bus.host_addr_i = 7'h07; bus.host_data_i = 8'h5A;
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.mem_write_req_o, bus.mem_addr_o, bus.mem_data_o, bus.ovf_o} !==
        {1'b1, 7'h07, 8'h5A, 1'b0}) begin
      bad++; $display("FAIL rstmid_after: got %b_%h_%h_%b want 1_07_5a_0", bus.mem_write_req_o,
                      bus.mem_addr_o, bus.mem_data_o, bus.ovf_o);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_host_write();
    test_host_read();
    test_local_read();
    test_host_loc_same();
    test_starve();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
